// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// downstream freeze and a pending-flush flag that survives a freeze.
// Optional build macro STALL_CNT_EN adds a saturating load-use stall counter;
// without it StallCnt_o is tied to zero and the port list is unchanged.
module id_ex_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IdValid_i,
    input  logic [4:0]        IdRs_i,
    input  logic [4:0]        IdRt_i,
    input  logic [4:0]        IdRd_i,
    input  logic [31:0]       IdData1_i,
    input  logic [31:0]       IdData2_i,
    input  logic [31:0]       IdImm_i,
    input  logic              IdRegWrite_i,
    input  logic              IdMemRead_i,
    input  logic              IdMemWrite_i,
    input  logic [CTRL_W-1:0] IdCtrl_i,
    input  logic              Flush_i,
    input  logic              ExStall_i,
    output logic              ExValid_o,
    output logic [4:0]        ExRs_o,
    output logic [4:0]        ExRt_o,
    output logic [4:0]        ExRd_o,
    output logic [31:0]       ExData1_o,
    output logic [31:0]       ExData2_o,
    output logic [31:0]       ExImm_o,
    output logic              ExRegWrite_o,
    output logic              ExMemRead_o,
    output logic              ExMemWrite_o,
    output logic [CTRL_W-1:0] ExCtrl_o,
    output logic              Stall_o,
    output logic [CNT_W-1:0]  StallCnt_o
);

    logic              exValidQ, exValidD;
    logic [4:0]        exRsQ, exRsD;
    logic [4:0]        exRtQ, exRtD;
    logic [4:0]        exRdQ, exRdD;
    logic [31:0]       exData1Q, exData1D;
    logic [31:0]       exData2Q, exData2D;
    logic [31:0]       exImmQ, exImmD;
    logic              exRegWriteQ, exRegWriteD;
    logic              exMemReadQ, exMemReadD;
    logic              exMemWriteQ, exMemWriteD;
    logic [CTRL_W-1:0] exCtrlQ, exCtrlD;
    logic              flushPendQ, flushPendD;
    logic              hazard;
    logic              srcMatch;

    // Load-use hazard: a valid load in EX writes a register the ID instruction reads.
    always_comb begin
        srcMatch = (exRdQ == IdRs_i) || (exRdQ == IdRt_i);
        hazard   = exValidQ && exMemReadQ && (exRdQ != 5'd0) && IdValid_i && srcMatch;
    end

    assign Stall_o = hazard;

    // Next state: freeze > flush (incl. pending) > load-use bubble > load from ID.
    always_comb begin
        exValidD    = exValidQ;
        exRsD       = exRsQ;
        exRtD       = exRtQ;
        exRdD       = exRdQ;
        exData1D    = exData1Q;
        exData2D    = exData2Q;
        exImmD      = exImmQ;
        exRegWriteD = exRegWriteQ;
        exMemReadD  = exMemReadQ;
        exMemWriteD = exMemWriteQ;
        exCtrlD     = exCtrlQ;
        flushPendD  = flushPendQ;

        if (ExStall_i) begin
            // Hold everything; remember a flush so it is applied once unfrozen.
            if (Flush_i) begin
                flushPendD = 1'b1;
            end
        end else if (Flush_i || flushPendQ || hazard) begin
            // Bubble: zero indices too so the forwarding unit never matches it.
            exValidD    = 1'b0;
            exRsD       = 5'd0;
            exRtD       = 5'd0;
            exRdD       = 5'd0;
            exData1D    = 32'd0;
            exData2D    = 32'd0;
            exImmD      = 32'd0;
            exRegWriteD = 1'b0;
            exMemReadD  = 1'b0;
            exMemWriteD = 1'b0;
            exCtrlD     = '0;
            flushPendD  = 1'b0;
        end else begin
            exValidD    = IdValid_i;
            exRsD       = IdRs_i;
            exRtD       = IdRt_i;
            exRdD       = IdRd_i;
            exData1D    = IdData1_i;
            exData2D    = IdData2_i;
            exImmD      = IdImm_i;
            exRegWriteD = IdRegWrite_i && IdValid_i;
            exMemReadD  = IdMemRead_i && IdValid_i;
            exMemWriteD = IdMemWrite_i && IdValid_i;
            exCtrlD     = IdValid_i ? IdCtrl_i : '0;
        end
    end

    // Pipeline state, cleared asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exValidQ    <= 1'b0;
            exRsQ       <= 5'd0;
            exRtQ       <= 5'd0;
            exRdQ       <= 5'd0;
            exData1Q    <= 32'd0;
            exData2Q    <= 32'd0;
            exImmQ      <= 32'd0;
            exRegWriteQ <= 1'b0;
            exMemReadQ  <= 1'b0;
            exMemWriteQ <= 1'b0;
            exCtrlQ     <= '0;
            flushPendQ  <= 1'b0;
        end else begin
            exValidQ    <= exValidD;
            exRsQ       <= exRsD;
            exRtQ       <= exRtD;
            exRdQ       <= exRdD;
            exData1Q    <= exData1D;
            exData2Q    <= exData2D;
            exImmQ      <= exImmD;
            exRegWriteQ <= exRegWriteD;
            exMemReadQ  <= exMemReadD;
            exMemWriteQ <= exMemWriteD;
            exCtrlQ     <= exCtrlD;
            flushPendQ  <= flushPendD;
        end
    end

    assign ExValid_o    = exValidQ;
    assign ExRs_o       = exRsQ;
    assign ExRt_o       = exRtQ;
    assign ExRd_o       = exRdQ;
    assign ExData1_o    = exData1Q;
    assign ExData2_o    = exData2Q;
    assign ExImm_o      = exImmQ;
    assign ExRegWrite_o = exRegWriteQ;
    assign ExMemRead_o  = exMemReadQ;
    assign ExMemWrite_o = exMemWriteQ;
    assign ExCtrl_o     = exCtrlQ;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stallCntQ, stallCntD;

    // Count load-use stall cycles that actually cost a bubble; saturate at all-ones.
    always_comb begin
        stallCntD = stallCntQ;
        if (hazard && !ExStall_i && (stallCntQ != '1)) begin
            stallCntD = stallCntQ + CNT_W'(1);
        end
    end

    // Counter state; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stallCntQ <= '0;
        end else begin
            stallCntQ <= stallCntD;
        end
    end

    assign StallCnt_o = stallCntQ;
`else
    assign StallCnt_o = '0;
`endif

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the 5-stage core. It captures decoded operands, register indices and control from ID, and presents them to EX and to the forwarding unit (ExRs_o/ExRt_o feed its Rs/Rt compare inputs). It also detects load-use hazards, inserts bubbles on hazard or branch flush, and freezes on a downstream stall. A pending-flush flag ensures that a flush raised during a freeze is not lost.

## Interface
Parameters:
- CTRL_W, default 8: width of the opaque EX/MEM/WB control bundle (ALUOp, ALUSrc, MemToReg, etc.).
- CNT_W, default 16: width of the stall performance counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- IdValid_i  in  1  the ID stage holds a real instruction.
- IdRs_i, IdRt_i  in  5 each  source register indices.
- IdRd_i  in  5  destination index, RegDst already resolved in ID.
- IdData1_i, IdData2_i  in  32 each  register-file read data.
- IdImm_i  in  32  sign-extended immediate.
- IdRegWrite_i, IdMemRead_i, IdMemWrite_i  in  1 each  explicit control bits.
- IdCtrl_i  in  CTRL_W  remaining control.
- Flush_i  in  1  branch/jump taken; the instruction in ID is squashed.
- ExStall_i  in  1  downstream busy; freeze this register.
- ExValid_o  out  1  EX holds a real instruction.
- ExRs_o, ExRt_o, ExRd_o  out  5 each  registered indices.
- ExData1_o, ExData2_o, ExImm_o  out  32 each  registered data.
- ExRegWrite_o, ExMemRead_o, ExMemWrite_o  out  1 each  registered control.
- ExCtrl_o  out  CTRL_W  registered control.
- Stall_o  out  1  load-use hazard; PC and IF/ID hold.
- StallCnt_o  out  CNT_W  stall-cycle count; see Configuration.

## Operation
- Hazard (combinational): Stall_o = ExValid_o & ExMemRead_o & (ExRd_o != 0) & IdValid_i & (ExRd_o == IdRs_i | ExRd_o == IdRt_i).
- Bubble: the register loads with ExValid_o=0, ExRegWrite_o=0, ExMemRead_o=0, ExMemWrite_o=0 and ExCtrl_o=0. Index and data fields also load zero, so a bubble never matches in the forwarding unit.
- Next-state priority per edge:
  1. ExStall_i=1: hold all fields. If Flush_i=1, set flush_pend.
  2. Flush_i=1 or flush_pend=1: load a bubble and clear flush_pend.
  3. Stall_o=1: load a bubble.
  4. Otherwise: load ID fields. ExValid_o <= IdValid_i. Write-enables are gated by IdValid_i, so an invalid ID loads zeroed control.
- Stall_o is not masked by ExStall_i. Upstream ORs both stall sources.
- Flush and load-use hazard in the same cycle: flush wins, a single bubble is inserted, and Stall_o still reads 1 that cycle.
- flush_pend is internal and not visible at any port.

## Timing
- Reset: every output register and flush_pend clear to 0 immediately on rst_i low, independent of clk_i. StallCnt_o=0. Stall_o evaluates to 0 because ExValid_o=0.
- Latency: ID inputs appear on Ex*_o one edge after sampling.
- Load-use hazard costs exactly one bubble. On the next edge EX holds the bubble, so Stall_o drops and the dependent instruction proceeds. The forwarding unit then supplies it from MEM.
- A freeze of N cycles holds the outputs for N edges. A flush requested during the freeze takes effect on the first unfrozen edge.
- Reset asserted mid-freeze or mid-flush discards flush_pend.

## Configuration
- STALL_CNT_EN defined: StallCnt_o increments by 1 on every edge where Stall_o=1 and ExStall_i=0. The count saturates at all-ones and clears only on reset.
- STALL_CNT_EN undefined: no counter logic is built, and StallCnt_o is tied to 0. The port list is identical in both builds.

## Test plan
- Reset: drive rst_i low mid-cycle with valid ID inputs -> all outputs 0 immediately. After release, first edge with IdValid_i=1, IdRd_i=5, IdData1_i=0x1234 -> ExRd_o=5, ExData1_o=0x1234, ExValid_o=1.
- Load-use: EX holds lw with ExRd_o=8; ID has IdRs_i=8 -> Stall_o=1. Next edge: ExValid_o=0, ExMemRead_o=0, Stall_o=0. Following edge: ExRs_o=8. StallCnt_o=1 when STALL_CNT_EN is defined.
- Register $0: EX holds lw with ExRd_o=0; ID has IdRs_i=0 -> Stall_o=0 and no bubble.
- Flush during freeze: ExStall_i=1 for 3 cycles with Flush_i pulsed in cycle 1 -> outputs unchanged for 3 edges. The first edge after ExStall_i falls loads a bubble; the next edge loads ID.
- Flush + hazard: Flush_i=1 and Stall_o=1 in the same cycle -> exactly one bubble. StallCnt_o increments by 1.
- Saturation (CNT_W=4, STALL_CNT_EN defined): 20 hazard cycles -> StallCnt_o=15.
